// File: rtl/btn_pkg.sv
// Shared types and default timing for the push-button conditioning path.
// Contents: FSM state enum, 25 MHz default debounce and long-press counts.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_e;

    localparam int unsigned DEBOUNCE_10MS = 250000;
    localparam int unsigned LONG_1S       = 25000000;

endpackage

// File: rtl/btn_debounce_if.sv
// Button bundle: raw pins in, debounced levels and one-cycle events out.
// Ports: i_btn (raw), o_level, o_press, o_release, o_long (all NUM_BTN wide).
interface btn_debounce_if #(
    parameter int NUM_BTN = 7
);
    logic [NUM_BTN-1:0] i_btn;
    logic [NUM_BTN-1:0] o_level;
    logic [NUM_BTN-1:0] o_press;
    logic [NUM_BTN-1:0] o_release;
    logic [NUM_BTN-1:0] o_long;

    modport master (
        input  i_btn,
        output o_level,
        output o_press,
        output o_release,
        output o_long
    );

    modport slave (
        output i_btn,
        input  o_level,
        input  o_press,
        input  o_release,
        input  o_long
    );
endinterface

// File: rtl/btn_channel.sv
// One button: polarity fix, 2-FF sync, debounce counter, press/long FSM.
// Ports: i_clk, i_rst_n, i_btn (raw) -> o_level, o_press, o_release, o_long.
module btn_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned LONG_CYCLES     = LONG_1S,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = {HW{1'b1}};

    logic          norm;
    logic          s1;
    logic          s2;
    logic          stable;
    logic [DW-1:0] dcnt;
    logic          flip;
    logic          rise;
    logic          fall;
    btn_state_e    state;
    logic [HW-1:0] hcnt;

    assign norm = i_btn ^ ACTIVE_LOW;

    // flip is the edge on which stable is about to change; the FSM
    // reacts to it directly so its pulses line up with o_level.
    assign flip = (s2 != stable) && (dcnt == D_LAST);
    assign rise = flip && s2;
    assign fall = flip && !s2;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            stable <= 1'b0;
            dcnt   <= '0;
        end else begin
            s1 <= norm;
            s2 <= s1;
            if (s2 == stable) begin
                dcnt <= '0;
            end else if (dcnt == D_LAST) begin
                stable <= s2;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            hcnt      <= '0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
        end else begin
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        o_press <= 1'b1;
                        hcnt    <= '0;
                        state   <= PRESSED;
                    end
                end
                PRESSED: begin
                    // release is checked first so it wins a tie with long
                    if (fall) begin
                        o_release <= 1'b1;
                        state     <= IDLE;
                    end else if (hcnt == H_LAST) begin
                        o_long <= 1'b1;
                        state  <= HELD;
                    end
                    if (hcnt != H_MAX) begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
                HELD: begin
                    if (fall) begin
                        o_release <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_level = stable;

endmodule

// File: rtl/btn_debounce.sv
// Conditions NUM_BTN raw buttons into clean levels and one-cycle events.
// Ports: i_clk, i_rst_n (sync, active-low), bus (btn_debounce_if.master).
module btn_debounce
    import btn_pkg::*;
#(
    parameter int                 NUM_BTN         = 7,
    parameter logic [NUM_BTN-1:0] ACTIVE_LOW_MASK = 7'b0000001,
    parameter int unsigned        DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int unsigned        LONG_CYCLES     = LONG_1S
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    btn_debounce_if.master    bus
);
    logic [NUM_BTN-1:0] level_w;
    logic [NUM_BTN-1:0] press_w;
    logic [NUM_BTN-1:0] release_w;
    logic [NUM_BTN-1:0] long_w;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW_MASK[g])
        ) u_ch (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_btn     (bus.i_btn[g]),
            .o_level   (level_w[g]),
            .o_press   (press_w[g]),
            .o_release (release_w[g]),
            .o_long    (long_w[g])
        );
    end

    assign bus.o_level   = level_w;
    assign bus.o_press   = press_w;
    assign bus.o_release = release_w;
    assign bus.o_long    = long_w;

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
Input-side counterpart to the LED output path: conditions the 7 raw ULX3S push-buttons into clean levels and single-cycle events.
- Per button: 2-FF synchronizer, polarity normalisation, debounce counter, press/release/long-press state machine.
- Sits between top-level `btn` pins and any logic that consumes button events (LED modes, counters, menus).

Parameters:
- NUM_BTN, 7, number of button channels.
- ACTIVE_LOW_MASK, 7'b0000001, bit set means that raw input is active-low (btn[0] PWR is active-low on ULX3S). The input is inverted before synchronisation.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (10 ms @ 25 MHz); must be ≥ 2.
- LONG_CYCLES, 25000000, cycles of debounced press before the long event fires (1 s @ 25 MHz); must be > DEBOUNCE_CYCLES.

Ports:
- i_clk  in  1  system clock (clk_25mhz).
- i_rst_n  in  1  synchronous reset, active-low.
- i_btn  in  NUM_BTN  raw asynchronous button pins.
- o_level  out  NUM_BTN  debounced level, 1 = pressed (polarity normalised).
- o_press  out  NUM_BTN  one-cycle pulse on debounced press.
- o_release  out  NUM_BTN  one-cycle pulse on debounced release.
- o_long  out  NUM_BTN  one-cycle pulse when a press has lasted LONG_CYCLES.

Behaviour:
- Reset (i_rst_n=0 at posedge): all synchronizer flops, stable levels and counters go to 0, FSM goes to IDLE, all outputs are 0 from the next cycle.
  - A button held through reset is reported as a fresh press after debounce.
- Normalisation: n = i_btn ^ ACTIVE_LOW_MASK, then 2-FF synchronizer s1→s2. No logic between s1 and s2.
- Debounce (per channel): counter dcnt, width $clog2(DEBOUNCE_CYCLES+1).
  - If s2 == stable: dcnt <= 0.
  - Else if dcnt == DEBOUNCE_CYCLES-1: stable <= s2 and dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - Any glitch back to the stable value restarts the count.
- Latency: if the raw input changes and holds, o_level changes DEBOUNCE_CYCLES+1 edges after the first edge that samples the new raw value into s1.
  - o_press and o_release are registered and assert in the same cycle that o_level changes.
- FSM per channel, states IDLE, PRESSED, HELD:
  - IDLE → PRESSED on stable 0→1: o_press=1 for 1 cycle; hold counter hcnt <= 0.
  - PRESSED: hcnt increments each cycle. At hcnt == LONG_CYCLES-1: o_long=1 for 1 cycle, go to HELD. Stable 1→0: o_release=1 for 1 cycle, go to IDLE.
  - HELD: no further o_long (no auto-repeat). Stable 1→0: o_release=1 for 1 cycle, go to IDLE.
  - If stable falls on the same cycle hcnt reaches LONG_CYCLES-1, release wins: o_release=1, o_long=0.
- hcnt width is $clog2(LONG_CYCLES); it saturates, never wraps.
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle.
- o_press, o_release and o_long are never high in the same cycle for one channel.

Decomposition:
- Shared package btn_pkg:
  - FSM state enum (IDLE/PRESSED/HELD, 2 bits).
  - Default timing constants for 25 MHz: DEBOUNCE_10MS=250000, LONG_1S=25000000.
- Sub-module btn_channel: one synchronizer + debounce + FSM, with scalar ports and parameters DEBOUNCE_CYCLES, LONG_CYCLES, ACTIVE_LOW.
  - btn_debounce instantiates NUM_BTN copies in a generate loop.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LONG_CYCLES=16.
1. Reset: hold i_rst_n=0 for 3 cycles with i_btn=7'b0000001 (idle) → o_level=0, o_press=o_release=o_long=0 during reset and for 20 cycles after.
2. Clean press: i_btn[1] 0→1 sampled at edge 0, held → o_level[1]=1 and o_press[1]=1 after edge 5, o_press[1]=0 after edge 6. Other bits stay 0.
3. Bounce: toggle i_btn[2] every 2 cycles for 20 cycles, then hold 0 → o_press[2], o_release[2] and o_level[2] remain 0 throughout.
4. Long press: hold i_btn[3] high 40 cycles → o_press[3] at edge 5, exactly one o_long[3] pulse 16 cycles later, no second pulse. Release → o_release[3] 5 edges after the release is first sampled.
5. Active-low and simultaneous: drive i_btn[0]=0 and i_btn[4]=1 on the same cycle → o_press[0] and o_press[4] pulse in the same cycle, o_level=7'b0010001.
6. Reset mid-hold: with btn[5] in HELD, assert i_rst_n=0 for 1 cycle with btn still pressed → outputs 0 next cycle, then o_press[5] 5 edges after reset release, and o_long[5] fires again 16 cycles after that press.
